// File: rtl/interval_arbiter_pkg.sv
// Shared types and default sizing for the interval arbiter.
// State encoding is common to the top and any block that needs to decode it.
package interval_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int NUM_REQ_DEF = 4;
   localparam int CNT_W_DEF   = 4;

endpackage

// File: rtl/interval_arbiter_if.sv
// Requester-side bundle: level requests and durations in; grant/done/busy/count out.
// master = requesters, slave = the arbiter.
interface interval_arbiter_if
   import interval_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int CNT_W   = CNT_W_DEF
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*CNT_W-1:0] dur;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       done;
   logic                     busy;
   logic [CNT_W-1:0]         count_out;

   modport master (output req, dur, input grant, done, busy, count_out);
   modport slave  (input req, dur, output grant, done, busy, count_out);

endinterface

// File: rtl/interval_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr, wrapping.
// No state; any_req_o qualifies winner_o.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic [IDX_W-1:0]   winner_o,
   output logic               any_req_o
);
   logic [IDX_W-1:0] sel;

   // Scan from the farthest offset down so the nearest set bit is written last and wins.
   always_comb begin
      winner_o  = '0;
      any_req_o = 1'b0;
      sel       = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sel = IDX_W'((int'(rr_ptr_i) + i) % NUM_REQ);
         if (req_i[sel]) begin
            winner_o  = sel;
            any_req_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interval_arbiter.sv
// Round-robin owner of the shared interval counter; grant 1 cycle after req, done D+1 cycles after grant.
// Requesters hold req level high for the whole interval; dropping it aborts without a done pulse.
module interval_arbiter
   import interval_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   interval_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   state_e               state_q;
   logic [IDX_W-1:0]     winner_q;
   logic [IDX_W-1:0]     rr_ptr_q;
   logic [IDX_W-1:0]     rr_ptr_d;
   logic [IDX_W-1:0]     winner;
   logic                 any_req;
   logic [CNT_W-1:0]     dur_q;
   logic [CNT_W-1:0]     dur_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [NUM_REQ-1:0]   grant_q;
   logic [NUM_REQ-1:0]   done_q;
   logic                 busy_q;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_i     (bus.req),
      .rr_ptr_i  (rr_ptr_q),
      .winner_o  (winner),
      .any_req_o (any_req)
   );

   always_comb begin
      dur_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) dur_d = bus.dur[i*CNT_W +: CNT_W];
      end
   end

   assign rr_ptr_d = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         winner_q <= '0;
         rr_ptr_q <= '0;
         dur_q    <= '0;
         cnt_q    <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= '0;
               if (any_req) begin
                  state_q  <= COUNT;
                  winner_q <= winner;
                  dur_q    <= dur_d;
                  grant_q  <= ONE << winner;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
               end
            end
            COUNT: begin
               // Abort takes priority over the terminal compare.
               if (!bus.req[winner_q]) begin
                  state_q  <= IDLE;
                  grant_q  <= '0;
                  busy_q   <= 1'b0;
                  cnt_q    <= '0;
                  rr_ptr_q <= rr_ptr_d;
               end else if (cnt_q == dur_q) begin
                  state_q <= DONE;
                  done_q  <= ONE << winner_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               state_q  <= IDLE;
               grant_q  <= '0;
               done_q   <= '0;
               busy_q   <= 1'b0;
               cnt_q    <= '0;
               rr_ptr_q <= rr_ptr_d;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.grant     = grant_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.count_out = cnt_q;

endmodule
